// File: rtl/sync_fifo_ctl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctl
//
// Single-clock FIFO with a registered fill level, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an encoded status state.
// Uses the same push/pop/full/empty contract as the clock-crossing variant.
//
// Optional feature macro: SYNC_FIFO_CTL_FWFT_EN
//   defined   -> first-word-fall-through: dataOut shows the head word whenever
//                the FIFO is not empty (0 when empty), ready = ~empty.
//   undefined -> registered read: an accepted pop loads dataOut on the next
//                cycle and pulses ready for that one cycle.
//
// Ports
//   ck          clock, all logic on the rising edge
//   srstN       synchronous active-low reset
//   push/dataIn write request and data (dropped while full)
//   pop         read request (dropped while empty)
//   dataOut     read data, ready marks it valid
//   full/empty, almostFull/almostEmpty   registered flags
//   level       registered word count, 0..FIFO_SIZE
//   overflow/underflow  sticky error flags, cleared by clrErr
//   status      EMPTY=0, IDLE=1, PUSH=2, POP=3, FULL=4
// -----------------------------------------------------------------------------
module sync_fifo_ctl #(
  parameter int  DATA_W    = 8,
  parameter int  FIFO_SIZE = 16,
  parameter int  AF_THRESH = FIFO_SIZE - 2,
  parameter int  AE_THRESH = 2,
  localparam int ADDR_W    = $clog2(FIFO_SIZE)
) (
  input  logic              ck,
  input  logic              srstN,
  input  logic              push,
  input  logic [DATA_W-1:0] dataIn,
  output logic              full,
  output logic              almostFull,
  input  logic              pop,
  output logic [DATA_W-1:0] dataOut,
  output logic              empty,
  output logic              almostEmpty,
  output logic              ready,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  output logic              underflow,
  input  logic              clrErr,
  output logic [2:0]        status
);

  typedef enum logic [2:0] {
    ST_EMPTY = 3'd0,
    ST_IDLE  = 3'd1,
    ST_PUSH  = 3'd2,
    ST_POP   = 3'd3,
    ST_FULL  = 3'd4
  } status_e;

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W + 1)'(FIFO_SIZE);
  localparam logic [ADDR_W:0] AF_LVL   = (ADDR_W + 1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE_LVL   = (ADDR_W + 1)'(AE_THRESH);

  logic [DATA_W-1:0] mem [FIFO_SIZE];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              af_q, af_d;
  logic              ae_q, ae_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  status_e           status_q, status_d;

  logic push_acc;
  logic pop_acc;

  // Accepts are gated by the registered flags only, so a push while full is
  // dropped even if a pop frees a slot in the same cycle (and vice versa).
  assign push_acc = push & ~full_q;
  assign pop_acc  = pop & ~empty_q;

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    status_d = ST_IDLE;

    if (push_acc) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_acc)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

    level_d = level_q + (ADDR_W + 1)'(push_acc) - (ADDR_W + 1)'(pop_acc);

    full_d  = (level_d == FULL_LVL);
    empty_d = (level_d == '0);
    af_d    = (level_d >= AF_LVL);
    ae_d    = (level_d <= AE_LVL);

    // Set beats clear when both happen in the same cycle.
    ovf_d = (push & full_q)  | (ovf_q & ~clrErr);
    unf_d = (pop  & empty_q) | (unf_q & ~clrErr);

    if (empty_d)                 status_d = ST_EMPTY;
    else if (full_d)             status_d = ST_FULL;
    else if (push_acc & ~pop_acc) status_d = ST_PUSH;
    else if (pop_acc & ~push_acc) status_d = ST_POP;
    else                         status_d = ST_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge ck) begin
    if (!srstN) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      status_q <= ST_EMPTY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      status_q <= status_d;
    end
  end

  // NOTE: the storage array has no reset; pointers and level define which
  // entries are valid, so stale contents are never observable.
  always_ff @(posedge ck) begin
    if (push_acc) mem[wr_ptr_q] <= dataIn;
  end

`ifdef SYNC_FIFO_CTL_FWFT_EN
  // Head word is visible as soon as it is stored; forced to 0 when empty.
  assign dataOut = empty_q ? '0 : mem[rd_ptr_q];
  assign ready   = ~empty_q;
`else
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              ready_q, ready_d;

  // dataOut holds until the next accepted pop; ready pulses for one cycle.
  always_comb begin
    dout_d  = dout_q;
    ready_d = pop_acc;
    if (pop_acc) dout_d = mem[rd_ptr_q];
  end

  always_ff @(posedge ck) begin
    if (!srstN) begin
      dout_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      ready_q <= ready_d;
    end
  end

  assign dataOut = dout_q;
  assign ready   = ready_q;
`endif

  assign full        = full_q;
  assign empty       = empty_q;
  assign almostFull  = af_q;
  assign almostEmpty = ae_q;
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign status      = status_q;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_ctl
//
// Self-checking bench for sync_fifo_ctl (DATA_W=8, FIFO_SIZE=16). A queue-based
// reference model predicts every output after each clock; directed steps are
// followed by a randomized phase with occasional resets.
// -----------------------------------------------------------------------------
module tb_sync_fifo_ctl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = DEPTH - 2;
  localparam int AE     = 2;

  logic              ck;
  logic              srstN;
  logic              push;
  logic [DATA_W-1:0] dataIn;
  logic              full;
  logic              almostFull;
  logic              pop;
  logic [DATA_W-1:0] dataOut;
  logic              empty;
  logic              almostEmpty;
  logic              ready;
  logic [4:0]        level;
  logic              overflow;
  logic              underflow;
  logic              clrErr;
  logic [2:0]        status;

  sync_fifo_ctl #(
    .DATA_W   (DATA_W),
    .FIFO_SIZE(DEPTH),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .ck         (ck),
    .srstN      (srstN),
    .push       (push),
    .dataIn     (dataIn),
    .full       (full),
    .almostFull (almostFull),
    .pop        (pop),
    .dataOut    (dataOut),
    .empty      (empty),
    .almostEmpty(almostEmpty),
    .ready      (ready),
    .level      (level),
    .overflow   (overflow),
    .underflow  (underflow),
    .clrErr     (clrErr),
    .status     (status)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] mq[$];
  bit                m_ovf;
  bit                m_unf;
  int                m_status;
  logic [DATA_W-1:0] m_dout;
  bit                m_ready;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int sz;
    sz = mq.size();
    check({tag, ".level"},       32'(level),       32'(sz));
    check({tag, ".full"},        32'(full),        32'(sz == DEPTH));
    check({tag, ".empty"},       32'(empty),       32'(sz == 0));
    check({tag, ".almostFull"},  32'(almostFull),  32'(sz >= AF));
    check({tag, ".almostEmpty"}, 32'(almostEmpty), 32'(sz <= AE));
    check({tag, ".overflow"},    32'(overflow),    32'(m_ovf));
    check({tag, ".underflow"},   32'(underflow),   32'(m_unf));
    check({tag, ".status"},      32'(status),      32'(m_status));
    check({tag, ".dataOut"},     32'(dataOut),     32'(m_dout));
    check({tag, ".ready"},       32'(ready),       32'(m_ready));
  endtask

  // Apply one cycle of stimulus, advance the model, then compare after the edge.
  task automatic step(input string tag, input bit p, input logic [DATA_W-1:0] d,
                      input bit r, input bit c);
    bit                push_ok;
    bit                pop_ok;
    int                sz;
    logic [DATA_W-1:0] popped;
    srstN  = 1'b1;
    push   = p;
    dataIn = d;
    pop    = r;
    clrErr = c;

    sz      = mq.size();
    push_ok = p && (sz < DEPTH);
    pop_ok  = r && (sz > 0);
    m_ovf   = (p && sz == DEPTH) || (m_ovf && !c);
    m_unf   = (r && sz == 0)     || (m_unf && !c);
    popped  = '0;
    if (pop_ok)  popped = mq.pop_front();
    if (push_ok) mq.push_back(d);

    sz = mq.size();
    if (sz == 0)                 m_status = 0;
    else if (sz == DEPTH)        m_status = 4;
    else if (push_ok && !pop_ok) m_status = 2;
    else if (pop_ok && !push_ok) m_status = 3;
    else                         m_status = 1;

`ifdef SYNC_FIFO_CTL_FWFT_EN
    m_dout  = (sz > 0) ? mq[0] : '0;
    m_ready = (sz > 0);
`else
    if (pop_ok) m_dout = popped;
    m_ready = pop_ok;
`endif

    @(posedge ck);
    #1;
    check_all(tag);
  endtask

  // Reset with push/pop active to confirm reset dominates.
  task automatic do_reset(input string tag);
    srstN  = 1'b0;
    push   = 1'b1;
    pop    = 1'b1;
    clrErr = 1'b0;
    dataIn = 8'hEE;
    mq.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_status = 0;
    m_dout   = '0;
    m_ready  = 1'b0;
    @(posedge ck);
    #1;
    check_all(tag);
  endtask

  initial begin
    srstN  = 1'b0;
    push   = 1'b0;
    pop    = 1'b0;
    clrErr = 1'b0;
    dataIn = '0;

    // Reset and idle
    @(posedge ck);
    #1;
    do_reset("reset");
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    // Fill with 0x01..0x10, then one push while full
    for (int i = 1; i <= DEPTH; i++) begin
      step($sformatf("fill%0d", i), 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 13) check("af_before_14", 32'(almostFull), 32'd0);
      if (i == 14) check("af_after_14", 32'(almostFull), 32'd1);
    end
    check("full_status", 32'(status), 32'd4);
    step("overflow_push", 1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_set", 32'(overflow), 32'd1);

    // Drain, then one pop while empty
    for (int i = 1; i <= DEPTH; i++) step($sformatf("drain%0d", i), 1'b0, 8'h00, 1'b1, 1'b0);
    check("drain_status", 32'(status), 32'd0);
    step("underflow_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set", 32'(underflow), 32'd1);
    step("clr_both", 1'b0, 8'h00, 1'b0, 1'b1);

    // Level 5, then simultaneous push/pop across pointer wrap
    for (int i = 0; i < 5; i++) step("pre_wrap", 1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step($sformatf("wrap%0d", i), 1'b1, 8'(8'h55 + i), 1'b1, 1'b0);
    check("wrap_level", 32'(level), 32'd5);
    check("wrap_status", 32'(status), 32'd1);

    // Overflow held through clrErr that coincides with another overflow
    for (int i = 0; i < 11; i++) step("refill", 1'b1, 8'(8'hA0 + i), 1'b0, 1'b0);
    step("ovf_again", 1'b1, 8'hBB, 1'b0, 1'b0);
    step("clr_vs_set", 1'b1, 8'hCC, 1'b0, 1'b1);
    check("clr_vs_set_ovf", 32'(overflow), 32'd1);
    step("clr_alone", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_alone_ovf", 32'(overflow), 32'd0);

    // Reset at level 9 discards contents
    for (int i = 0; i < 7; i++) step("to_nine", 1'b0, 8'h00, 1'b1, 1'b0);
    check("nine_level", 32'(level), 32'd9);
    do_reset("mid_reset");
    step("post_reset_push", 1'b1, 8'h3C, 1'b0, 1'b0);
    step("post_reset_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    check("post_reset_data", 32'(dataOut), 32'h3C);

    // Randomized traffic with biased phases to reach both boundaries
    for (int i = 0; i < 600; i++) begin
      int pp;
      int rp;
      pp = ((i / 50) % 2 == 0) ? 70 : 30;
      rp = 100 - pp;
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_reset");
      end else begin
        step("rand",
             $urandom_range(0, 99) < pp,
             8'($urandom),
             $urandom_range(0, 99) < rp,
             $urandom_range(0, 99) < 5);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
